// File: rtl/sad_min_tracker.sv
// sad_min_tracker
//   Tracks the minimum SAD over a raster-ordered motion-search window and
//   reports its value and position once all candidates have been seen.
//
// Ports
//   Clk       : single clock, all state changes on the rising edge
//   Rst       : synchronous active-high reset
//   Start     : one-cycle pulse, begins (or restarts) a search
//   SadValid  : SadIn carries a candidate this cycle
//   SadIn     : unsigned candidate SAD, raster index order
//   Busy      : search in progress
//   Done      : one-cycle pulse, result outputs just updated
//   MinSad    : smallest SAD of the last completed search
//   MinIndex  : raster index of MinSad
//   BestX     : MinIndex >> LOG2_COLS
//   BestY     : MinIndex[LOG2_COLS-1:0]
//   Count     : candidates accepted in the current search
module sad_min_tracker #(
  parameter int SAD_W     = 16,
  parameter int LOG2_COLS = 6,
  parameter int LOG2_ROWS = 6,
  parameter int IDX_W     = LOG2_COLS + LOG2_ROWS
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 SadValid,
  input  logic [SAD_W-1:0]     SadIn,
  output logic                 Busy,
  output logic                 Done,
  output logic [SAD_W-1:0]     MinSad,
  output logic [IDX_W-1:0]     MinIndex,
  output logic [LOG2_ROWS-1:0] BestX,
  output logic [LOG2_COLS-1:0] BestY,
  output logic [IDX_W:0]       Count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam logic [IDX_W:0] LAST = {1'b0, {IDX_W{1'b1}}};
  localparam logic [IDX_W:0] ONE  = {{IDX_W{1'b0}}, 1'b1};

  state_t             state_q,   state_d;
  logic [IDX_W:0]     count_q,   count_d;
  logic [SAD_W-1:0]   run_min_q, run_min_d;
  logic [IDX_W-1:0]   run_idx_q, run_idx_d;
  logic [SAD_W-1:0]   min_sad_q, min_sad_d;
  logic [IDX_W-1:0]   min_idx_q, min_idx_d;

  logic               take;
  logic [SAD_W-1:0]   cand_min;
  logic [IDX_W-1:0]   cand_idx;

  // Candidate 0 always wins so an all-ones SAD is still captured; later
  // candidates need a strictly smaller value, so the earliest tie is kept.
  always_comb begin
    take     = (count_q == '0) || (SadIn < run_min_q);
    cand_min = take ? SadIn : run_min_q;
    cand_idx = take ? count_q[IDX_W-1:0] : run_idx_q;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    run_min_d = run_min_q;
    run_idx_d = run_idx_q;
    min_sad_d = min_sad_q;
    min_idx_d = min_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d   = ST_SCAN;
          count_d   = '0;
          run_min_d = '1;
          run_idx_d = '0;
        end
      end

      ST_SCAN: begin
        if (Start) begin
          // Abort: restart in place, a coincident sample is dropped.
          count_d   = '0;
          run_min_d = '1;
          run_idx_d = '0;
        end else if (SadValid) begin
          count_d   = count_q + ONE;
          run_min_d = cand_min;
          run_idx_d = cand_idx;
          if (count_q == LAST) begin
            // Results include this final sample, so load from the
            // candidate values rather than the running registers.
            state_d   = ST_DONE;
            min_sad_d = cand_min;
            min_idx_d = cand_idx;
          end
        end
      end

      ST_DONE: begin
        if (Start) begin
          state_d   = ST_SCAN;
          count_d   = '0;
          run_min_d = '1;
          run_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      run_min_q <= '1;
      run_idx_q <= '0;
      min_sad_q <= '0;
      min_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      run_min_q <= run_min_d;
      run_idx_q <= run_idx_d;
      min_sad_q <= min_sad_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign Busy     = (state_q == ST_SCAN);
  assign Done     = (state_q == ST_DONE);
  assign MinSad   = min_sad_q;
  assign MinIndex = min_idx_q;
  assign BestX    = min_idx_q[IDX_W-1:LOG2_COLS];
  assign BestY    = min_idx_q[LOG2_COLS-1:0];
  assign Count    = count_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
module tb_sad_min_tracker;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic       SadValid = 1'b0;
  logic [7:0] SadIn = '0;
  logic       Busy, Done;
  logic [7:0] MinSad;
  logic [3:0] MinIndex;
  logic [1:0] BestX, BestY;
  logic [4:0] Count;

  logic        Start2 = 1'b0;
  logic        SadValid2 = 1'b0;
  logic [15:0] SadIn2 = '0;
  logic        Busy2, Done2;
  logic [15:0] MinSad2;
  logic [11:0] MinIndex2;
  logic [5:0]  BestX2, BestY2;
  logic [12:0] Count2;

  int checks = 0;
  int errors = 0;
  int dones;

  always #5 Clk = ~Clk;

  sad_min_tracker #(.SAD_W(8), .LOG2_COLS(2), .LOG2_ROWS(2)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .SadValid(SadValid), .SadIn(SadIn),
    .Busy(Busy), .Done(Done), .MinSad(MinSad), .MinIndex(MinIndex),
    .BestX(BestX), .BestY(BestY), .Count(Count)
  );

  sad_min_tracker dut_def (
    .Clk(Clk), .Rst(Rst), .Start(Start2), .SadValid(SadValid2), .SadIn(SadIn2),
    .Busy(Busy2), .Done(Done2), .MinSad(MinSad2), .MinIndex(MinIndex2),
    .BestX(BestX2), .BestY(BestY2), .Count(Count2)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset, overriding a concurrent Start/SadValid
    Start = 1'b1; SadValid = 1'b1; SadIn = 8'd9;
    tick();
    Start = 1'b0; SadValid = 1'b0;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_count", 32'(Count), 0);
    chk("rst_minsad", 32'(MinSad), 0);
    chk("rst_minidx", 32'(MinIndex), 0);
    chk("rst_bestx", 32'(BestX), 0);
    chk("rst_besty", 32'(BestY), 0);
    Rst = 1'b0;
    tick();
    chk("idle_busy", 32'(Busy), 0);

    // Descending 50..35 back-to-back
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t1_busy", 32'(Busy), 1);
    chk("t1_count0", 32'(Count), 0);
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      SadValid = 1'b1; SadIn = 8'(50 - i);
      tick();
      if (i < 15 && Done) dones++;
    end
    SadValid = 1'b0;
    chk("t1_early_done", 32'(dones), 0);
    chk("t1_done", 32'(Done), 1);
    chk("t1_minsad", 32'(MinSad), 35);
    chk("t1_minidx", 32'(MinIndex), 15);
    chk("t1_bestx", 32'(BestX), 3);
    chk("t1_besty", 32'(BestY), 3);
    chk("t1_count", 32'(Count), 16);
    tick();
    chk("t1_done_once", 32'(Done), 0);
    chk("t1_idle", 32'(Busy), 0);
    chk("t1_hold", 32'(MinSad), 35);

    // Ties at 6 and 9: earliest wins
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      SadValid = 1'b1; SadIn = (i == 6 || i == 9) ? 8'd5 : 8'd20;
      tick();
      if (i == 10) chk("t2_hold_mid", 32'(MinSad), 35);
    end
    SadValid = 1'b0;
    chk("t2_done", 32'(Done), 1);
    chk("t2_minsad", 32'(MinSad), 5);
    chk("t2_minidx", 32'(MinIndex), 6);
    chk("t2_bestx", 32'(BestX), 1);
    chk("t2_besty", 32'(BestY), 2);
    tick();

    // All 255 with gaps
    Start = 1'b1; tick(); Start = 1'b0;
    dones = 0;
    for (int i = 0; i < 36; i++) begin
      SadValid = (i % 2 == 0) && (i < 32); SadIn = 8'd255;
      tick();
      if (Done) dones++;
    end
    SadValid = 1'b0;
    chk("t3_dones", 32'(dones), 1);
    chk("t3_minsad", 32'(MinSad), 255);
    chk("t3_minidx", 32'(MinIndex), 0);
    chk("t3_count", 32'(Count), 16);

    // Abort after 8 samples, restart with a coincident (ignored) sample
    Start = 1'b1; tick(); Start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      SadValid = 1'b1; SadIn = 8'd1;
      tick();
      if (Done) dones++;
    end
    Start = 1'b1; SadValid = 1'b1; SadIn = 8'd0;
    tick();
    Start = 1'b0;
    chk("t4_restart_count", 32'(Count), 0);
    chk("t4_restart_busy", 32'(Busy), 1);
    for (int i = 0; i < 16; i++) begin
      SadValid = 1'b1; SadIn = (i == 10) ? 8'd3 : 8'd100;
      tick();
      if (Done) dones++;
      if (i == 14) chk("t4_hold", 32'(MinSad), 255);
    end
    SadValid = 1'b0;
    chk("t4_dones", 32'(dones), 1);
    chk("t4_minsad", 32'(MinSad), 3);
    chk("t4_minidx", 32'(MinIndex), 10);
    chk("t4_bestx", 32'(BestX), 2);
    chk("t4_besty", 32'(BestY), 2);

    // Start while in DONE goes straight to SCAN
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t5_busy", 32'(Busy), 1);
    chk("t5_count", 32'(Count), 0);

    // Reset after 5 samples
    for (int i = 0; i < 5; i++) begin
      SadValid = 1'b1; SadIn = 8'(7 + i);
      tick();
    end
    chk("t5_count5", 32'(Count), 5);
    Rst = 1'b1; tick(); Rst = 1'b0;
    chk("t5_busy0", 32'(Busy), 0);
    chk("t5_done0", 32'(Done), 0);
    chk("t5_count0", 32'(Count), 0);
    chk("t5_minsad0", 32'(MinSad), 0);
    chk("t5_minidx0", 32'(MinIndex), 0);
    chk("t5_bestx0", 32'(BestX), 0);
    chk("t5_besty0", 32'(BestY), 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Done) dones++;
    end
    SadValid = 1'b0;
    chk("t5_no_done", 32'(dones), 0);
    chk("t5_idle", 32'(Busy), 0);

    // Default parameters: 4096 candidates, min 1 at 200 (tie at 3000)
    Start2 = 1'b1; tick(); Start2 = 1'b0;
    dones = 0;
    for (int i = 0; i < 4096; i++) begin
      SadValid2 = 1'b1;
      SadIn2 = (i == 200 || i == 3000) ? 16'd1 : 16'(1000 + (i % 50));
      tick();
      if (Done2 && i < 4095) dones++;
    end
    SadValid2 = 1'b0;
    chk("t6_early_done", 32'(dones), 0);
    chk("t6_done", 32'(Done2), 1);
    chk("t6_count", 32'(Count2), 4096);
    chk("t6_minsad", 32'(MinSad2), 1);
    chk("t6_minidx", 32'(MinIndex2), 200);
    chk("t6_bestx", 32'(BestX2), 3);
    chk("t6_besty", 32'(BestY2), 8);
    tick();
    chk("t6_idle", 32'(Busy2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
